mem_arbiter: RTL

Two-requester arbiter and sequencer for the shared 64K x 32 single-port memory. It accepts instruction-fetch reads and data load/store requests, grants one access at a time with round-robin fairness, and drives the memory's `rw` / `readInstruction` / `addr` / `din` controls from registered state. It returns read data with a one-cycle `valid` pulse. It sits between the fetch/memory stages of the core and the memory instance, and is the only block allowed to drive the memory controls.

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch / data) arbiter and sequencer for the
// shared 64K x 32 single-port memory. One access is in flight at a time;
// ties are broken round-robin. All memory controls come from registers so
// the memory only ever sees a clean command or the idle dummy read.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no access in flight; requests sampled at the closing edge
// ISSUE | granted command on ram_*; memory performs it at the closing edge
// RESP  | winner's valid high, read data on *_rdata; requests sampled again
module mem_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_req,
    input  logic [15:0]      if_addr,
    output logic             if_gnt,
    output logic             if_valid,
    output logic [31:0]      if_rdata,
    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [15:0]      dm_addr,
    input  logic [31:0]      dm_wdata,
    output logic             dm_gnt,
    output logic             dm_valid,
    output logic [31:0]      dm_rdata,
    output logic             ram_rw,
    output logic             ram_read_instr,
    output logic [15:0]      ram_addr,
    output logic [31:0]      ram_din,
    input  logic [31:0]      ram_dout,
    input  logic [31:0]      ram_dout_mem,
    output logic [CNT_W-1:0] if_count,
    output logic [CNT_W-1:0] dm_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t state;
    logic   last_dm;   // most recent grant went to the data port
    logic   cur_dm;    // owner of the access currently in flight
    logic   any_req;
    logic   pick_dm;

    // Read data is not registered here: the memory output is already a
    // registered value that is stable for the whole RESP cycle.
    assign if_rdata = ram_dout;
    assign dm_rdata = ram_dout_mem;

    // Winner selection: a lone requester wins; on a tie the port that did
    // not receive the previous grant wins.
    always_comb begin
        any_req = if_req | dm_req;
        pick_dm = dm_req & (~if_req | ~last_dm);
    end

    // Sequencer: grant, present the command for one cycle, then report
    // completion. Pulses and the memory command default back to idle every
    // cycle, so the memory sees the dummy read unless an access is issuing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            last_dm        <= 1'b0;
            cur_dm         <= 1'b0;
            if_gnt         <= 1'b0;
            dm_gnt         <= 1'b0;
            if_valid       <= 1'b0;
            dm_valid       <= 1'b0;
            ram_rw         <= 1'b1;
            ram_read_instr <= 1'b0;
            ram_addr       <= '0;
            ram_din        <= '0;
            if_count       <= '0;
            dm_count       <= '0;
        end else begin
            if_gnt         <= 1'b0;
            dm_gnt         <= 1'b0;
            if_valid       <= 1'b0;
            dm_valid       <= 1'b0;
            ram_rw         <= 1'b1;
            ram_read_instr <= 1'b0;
            ram_addr       <= '0;
            ram_din        <= '0;
            case (state)
                S_IDLE, S_RESP: begin
                    if (any_req) begin
                        state   <= S_ISSUE;
                        cur_dm  <= pick_dm;
                        last_dm <= pick_dm;
                        if (pick_dm) begin
                            dm_gnt   <= 1'b1;
                            dm_count <= dm_count + 1'b1;
                            ram_addr <= dm_addr;
                            ram_rw   <= ~dm_we;
                            if (dm_we) begin
                                ram_din <= dm_wdata;
                            end
                        end else begin
                            if_gnt         <= 1'b1;
                            if_count       <= if_count + 1'b1;
                            ram_addr       <= if_addr;
                            ram_read_instr <= 1'b1;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    // Requests are deliberately ignored here: this is the
                    // grant cycle, when the requester may still hold req.
                    state <= S_RESP;
                    if (cur_dm) begin
                        dm_valid <= 1'b1;
                    end else begin
                        if_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
